// File: rtl/booth_mult4_if.sv
// booth_mult4_if: start/busy/done handshake and operand/product bus for booth_mult4.
// Optional BOOTH_MAG_OUT_EN adds the neg/mag display outputs.
//
// Handshake: the master drives start with a/b. A request is accepted on a rising
// edge only while the unit is idle (busy=0). busy stays high from the accepting
// edge until the cycle after done. done is a one-cycle pulse, and product is
// valid from that cycle onward. start is ignored while busy=1 and is not queued.
interface booth_mult4_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [1:0] dbg_state;
`ifdef BOOTH_MAG_OUT_EN
  logic       neg;
  logic [6:0] mag;

  modport master (output start, a, b,
                  input  busy, done, product, dbg_state, neg, mag);
  modport slave  (input  start, a, b,
                  output busy, done, product, dbg_state, neg, mag);
`else
  modport master (output start, a, b,
                  input  busy, done, product, dbg_state);
  modport slave  (input  start, a, b,
                  output busy, done, product, dbg_state);
`endif
endinterface

// File: rtl/booth_mult4.sv
// booth_mult4: sequential radix-2 Booth multiplier, 4-bit signed x 4-bit signed
// -> 8-bit signed product. Four RUN steps follow the accepting edge. product is
// loaded on the last step and is held until the next completion or until reset.
// Optional macro BOOTH_MAG_OUT_EN: adds registered neg/mag outputs (sign and |product|).
module booth_mult4 (
  input  logic         clk,
  input  logic         rst,
  booth_mult4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       busy_q, done_q;

  // Datapath: 5-bit accumulator and multiplicand, so that -M for M=-8 fits.
  logic [4:0] m_q;
  logic [4:0] acc_q;
  logic [3:0] q_q;
  logic       qm1_q;
  logic [1:0] cnt_q;
  logic [7:0] product_q;

  logic [4:0] acc_sum;
  logic [4:0] acc_n;
  logic [3:0] q_n;
  logic       qm1_n;
  logic [7:0] prod_next;
  logic       last_step;

`ifdef BOOTH_MAG_OUT_EN
  logic       neg_q;
  logic [6:0] mag_q;
  logic [7:0] prod_negated;
`endif

  assign last_step = (state_q == RUN) && (cnt_q == 2'd3);

  // Next-state logic for the IDLE -> RUN x4 -> DONE -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One Booth step: add/subtract M by {Q[0], q-1}, then arithmetic shift {A,Q,q-1}.
  always_comb begin
    acc_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + m_q;
      2'b10:   acc_sum = acc_q - m_q;
      default: acc_sum = acc_q;
    endcase
    acc_n     = {acc_sum[4], acc_sum[4:1]};
    q_n       = {acc_sum[0], q_q[3:1]};
    qm1_n     = q_q[0];
    // A[4] equals A[3] after the final step, so dropping it is exact.
    prod_next = {acc_n[3:0], q_n};
  end

`ifdef BOOTH_MAG_OUT_EN
  // Two's-complement negation for the magnitude output; |-56..64| fits in 7 bits.
  always_comb begin
    prod_negated = ~prod_next + 8'd1;
  end
`endif

  // State register with registered busy/done, so there is no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= last_step;
    end
  end

  // Datapath registers: load on acceptance, step in RUN, capture the result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= 5'd0;
      acc_q     <= 5'd0;
      q_q       <= 4'd0;
      qm1_q     <= 1'b0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
`ifdef BOOTH_MAG_OUT_EN
      neg_q     <= 1'b0;
      mag_q     <= 7'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q   <= {bus.a[3], bus.a};
            acc_q <= 5'd0;
            q_q   <= bus.b;
            qm1_q <= 1'b0;
            cnt_q <= 2'd0;
          end
        end
        RUN: begin
          acc_q <= acc_n;
          q_q   <= q_n;
          qm1_q <= qm1_n;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            product_q <= prod_next;
`ifdef BOOTH_MAG_OUT_EN
            neg_q     <= prod_next[7];
            mag_q     <= prod_next[7] ? prod_negated[6:0] : prod_next[6:0];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.product   = product_q;
  assign bus.dbg_state = state_q;
`ifdef BOOTH_MAG_OUT_EN
  assign bus.neg       = neg_q;
  assign bus.mag       = mag_q;
`endif

endmodule
